// File: rtl/tone_arb_pkg.sv
// tone_arb_pkg: shared note type, rest value and FSM states for the tone output arbiter
package tone_arb_pkg;
  typedef logic [3:0] note_t;
  localparam note_t NOTE_REST = 4'h0;
  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} state_e;
endpackage

// File: rtl/tone_output_arbiter_tick_prescaler.sv
// tick_prescaler: free-running divider producing a one-cycle tick every TICK_DIV clocks
// Ports: clk, reset (async, active-high), tick (high while the count is TICK_DIV-1)
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  logic [CW-1:0] cnt_q;
  assign tick = cnt_q == LAST;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= tick ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/tone_output_arbiter.sv
// tone_output_arbiter: grants one note requester at a time onto the piezo/LED pair
// Ports: clk, reset (async, active-high), req/note_in (per-requester level request and
// 4-bit note), grant (one-hot), done (release pulse), busy, active_id, piezo_out, led_out.
// Macro TONE_ARB_ROUND_ROBIN_EN selects round-robin arbitration; fixed priority otherwise.
module tone_output_arbiter
  import tone_arb_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int TICK_DIV     = 4,
  parameter int MIN_ON_TICKS = 2,
  parameter int MAX_ON_TICKS = 0,
  parameter int GAP_TICKS    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [4*NUM_REQ-1:0]       note_in,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output note_t                      piezo_out,
  output note_t                      led_out
);
  localparam int IW   = $clog2(NUM_REQ);
  localparam int OMAX = MIN_ON_TICKS > MAX_ON_TICKS ? MIN_ON_TICKS : MAX_ON_TICKS;
  localparam int OW   = $clog2(OMAX + 1);
  localparam int GW   = GAP_TICKS > 0 ? $clog2(GAP_TICKS + 1) : 1;
  state_e               state_q, state_d;
  logic [OW-1:0]        on_cnt_q, on_cnt_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [IW-1:0]        id_q, id_d;
  note_t                note_q, note_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d, done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 tick, found, rel;
  logic [IW-1:0]        win;
  note_t                notes [NUM_REQ];
`ifdef TONE_ARB_ROUND_ROBIN_EN
  logic [IW-1:0]        rr_q, rr_d;
  logic [2*NUM_REQ-1:0] dbl;
`endif
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (.clk(clk), .reset(reset), .tick(tick));
  always_comb
    for (int k = 0; k < NUM_REQ; k++) notes[k] = note_in[4*k +: 4];
  // Descending scan so the lowest qualifying position is the one left standing.
  always_comb begin
    found = 1'b0;
    win   = '0;
`ifdef TONE_ARB_ROUND_ROBIN_EN
    dbl = {req, req} >> rr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (dbl[k]) begin
        found = 1'b1;
        win   = IW'((int'(rr_q) + k) % NUM_REQ);
      end
`else
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[k]) begin
        found = 1'b1;
        win   = IW'(k);
      end
`endif
  end
  assign rel = (!req[id_q] && on_cnt_q >= OW'(MIN_ON_TICKS)) ||
               (MAX_ON_TICKS != 0 && on_cnt_q == OW'(MAX_ON_TICKS));
  always_comb begin
    state_d   = state_q;
    on_cnt_d  = on_cnt_q;
    gap_cnt_d = gap_cnt_q;
    id_d      = id_q;
    note_d    = note_q;
    grant_d   = grant_q;
    done_d    = '0;
`ifdef TONE_ARB_ROUND_ROBIN_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      ST_IDLE:
        if (found) begin
          state_d  = ST_PLAY;
          id_d     = win;
          note_d   = notes[win];
          grant_d  = NUM_REQ'(1) << win;
          on_cnt_d = '0;
`ifdef TONE_ARB_ROUND_ROBIN_EN
          rr_d     = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
        end
      ST_PLAY: begin
        if (tick && on_cnt_q != OW'(OMAX)) on_cnt_d = on_cnt_q + 1'b1;
        if (rel) begin
          state_d   = GAP_TICKS > 0 ? ST_GAP : ST_IDLE;
          grant_d   = '0;
          note_d    = NOTE_REST;
          done_d    = grant_q;
          gap_cnt_d = '0;
          id_d      = '0;
        end
      end
      ST_GAP:
        if (gap_cnt_q == GW'(GAP_TICKS)) state_d = ST_IDLE;
        else if (tick) gap_cnt_d = gap_cnt_q + 1'b1;
      default: state_d = ST_IDLE;
    endcase
    busy_d = state_d != ST_IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= ST_IDLE;
      on_cnt_q  <= '0;
      gap_cnt_q <= '0;
      id_q      <= '0;
      note_q    <= NOTE_REST;
      grant_q   <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
`ifdef TONE_ARB_ROUND_ROBIN_EN
      rr_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      on_cnt_q  <= on_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      id_q      <= id_d;
      note_q    <= note_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
`ifdef TONE_ARB_ROUND_ROBIN_EN
      rr_q      <= rr_d;
`endif
    end
  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign active_id = id_q;
  assign piezo_out = note_q;
  assign led_out   = note_q;
endmodule

// File: tb/tb_tone_output_arbiter.sv
// tb_tone_output_arbiter: directed vector table plus timeout, reset and round-robin sequences
module tb_tone_output_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0, req2 = '0;
  logic [11:0] note_in = '0, note2 = '0;
  logic [2:0]  grant, done, grant2, done2;
  logic        busy, busy2;
  logic [1:0]  active_id, active_id2;
  logic [3:0]  piezo_out, led_out, piezo2, led2;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [2:0]  req;
    logic [11:0] notes;
    logic [2:0]  g;
    logic [2:0]  d;
    logic        b;
    logic [1:0]  id;
    logic [3:0]  p;
  } vec_t;
  vec_t vecs[$];
  always #5 clk = ~clk;
  tone_output_arbiter #(.NUM_REQ(3), .TICK_DIV(2), .MIN_ON_TICKS(2), .MAX_ON_TICKS(0), .GAP_TICKS(1)) dut (
    .clk(clk), .reset(reset), .req(req), .note_in(note_in), .grant(grant), .done(done),
    .busy(busy), .active_id(active_id), .piezo_out(piezo_out), .led_out(led_out));
  tone_output_arbiter #(.NUM_REQ(3), .TICK_DIV(2), .MIN_ON_TICKS(2), .MAX_ON_TICKS(3), .GAP_TICKS(1)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .note_in(note2), .grant(grant2), .done(done2),
    .busy(busy2), .active_id(active_id2), .piezo_out(piezo2), .led_out(led2));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void add(input int n, input logic [2:0] r, input logic [11:0] nt,
                              input logic [2:0] g, input logic [2:0] d, input logic b,
                              input logic [1:0] id, input logic [3:0] p);
    vec_t v;
    v = '{req: r, notes: nt, g: g, d: d, b: b, id: id, p: p};
    repeat (n) vecs.push_back(v);
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int on, rel_seen, got;
    logic [2:0] exp_regrant;
    add(10, 3'b010, 12'h050, 3'b010, 3'b000, 1, 1, 4'h5);
    add(1,  3'b000, 12'h050, 3'b000, 3'b010, 1, 0, 4'h0);
    add(1,  3'b000, 12'h050, 3'b000, 3'b000, 1, 0, 4'h0);
    add(2,  3'b000, 12'h050, 3'b000, 3'b000, 0, 0, 4'h0);
    add(1,  3'b001, 12'h003, 3'b001, 3'b000, 1, 0, 4'h3);
    add(3,  3'b000, 12'h003, 3'b001, 3'b000, 1, 0, 4'h3);
    add(1,  3'b000, 12'h003, 3'b000, 3'b001, 1, 0, 4'h0);
    add(1,  3'b000, 12'h003, 3'b000, 3'b000, 1, 0, 4'h0);
    add(2,  3'b000, 12'h003, 3'b000, 3'b000, 0, 0, 4'h0);
    add(6,  3'b101, 12'h701, 3'b001, 3'b000, 1, 0, 4'h1);
    add(1,  3'b100, 12'h701, 3'b000, 3'b001, 1, 0, 4'h0);
    add(1,  3'b100, 12'h701, 3'b000, 3'b000, 1, 0, 4'h0);
    add(1,  3'b100, 12'h701, 3'b000, 3'b000, 0, 0, 4'h0);
    add(1,  3'b100, 12'h701, 3'b100, 3'b000, 1, 2, 4'h7);
    add(4,  3'b000, 12'h701, 3'b100, 3'b000, 1, 2, 4'h7);
    add(1,  3'b000, 12'h701, 3'b000, 3'b100, 1, 0, 4'h0);
    add(1,  3'b000, 12'h701, 3'b000, 3'b000, 1, 0, 4'h0);
    add(1,  3'b000, 12'h701, 3'b000, 3'b000, 0, 0, 4'h0);
    add(1,  3'b010, 12'h050, 3'b010, 3'b000, 1, 1, 4'h5);
    add(2,  3'b010, 12'h090, 3'b010, 3'b000, 1, 1, 4'h5);
    add(2,  3'b000, 12'h090, 3'b010, 3'b000, 1, 1, 4'h5);
    add(1,  3'b000, 12'h090, 3'b000, 3'b010, 1, 0, 4'h0);
    add(1,  3'b000, 12'h090, 3'b000, 3'b000, 1, 0, 4'h0);
    add(1,  3'b000, 12'h090, 3'b000, 3'b000, 0, 0, 4'h0);
    add(1,  3'b100, 12'h000, 3'b100, 3'b000, 1, 2, 4'h0);
    add(4,  3'b000, 12'h000, 3'b100, 3'b000, 1, 2, 4'h0);
    add(1,  3'b000, 12'h000, 3'b000, 3'b100, 1, 0, 4'h0);
    add(1,  3'b000, 12'h000, 3'b000, 3'b000, 1, 0, 4'h0);
    add(1,  3'b000, 12'h000, 3'b000, 3'b000, 0, 0, 4'h0);
    #12;
    chk("reset grant", grant, 0);
    chk("reset piezo", piezo_out, 0);
    chk("reset busy", busy, 0);
    #5 reset = 1'b0;
    foreach (vecs[i]) begin
      req = vecs[i].req;
      note_in = vecs[i].notes;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d grant", i), grant, vecs[i].g);
      chk($sformatf("v%0d done", i), done, vecs[i].d);
      chk($sformatf("v%0d busy", i), busy, vecs[i].b);
      chk($sformatf("v%0d active_id", i), active_id, vecs[i].id);
      chk($sformatf("v%0d piezo", i), piezo_out, vecs[i].p);
      chk($sformatf("v%0d led", i), led_out, vecs[i].p);
    end
    req = 3'b010;
    note_in = 12'h050;
    @(posedge clk);
    #1;
    chk("pre-reset grant", grant, 3'b010);
    #2 reset = 1'b1;
    #1;
    chk("async reset grant", grant, 0);
    chk("async reset piezo", piezo_out, 0);
    chk("async reset led", led_out, 0);
    chk("async reset busy", busy, 0);
    chk("async reset done", done, 0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset grant", grant, 3'b010);
    chk("post-reset piezo", piezo_out, 4'h5);
    chk("post-reset active_id", active_id, 1);
    req = '0;
    req2 = 3'b011;
    note2 = 12'h021;
    got = 0;
    for (int k = 0; k < 4 && got == 0; k++) begin
      @(posedge clk);
      #1;
      got = int'(grant2 != 0);
    end
    chk("max first grant", grant2, 3'b001);
    chk("max first piezo", piezo2, 4'h1);
    chk("max first led", led2, 4'h1);
    chk("max first id", active_id2, 0);
    on = 1;
    rel_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (grant2 !== 3'b001) begin
        rel_seen = 1;
        break;
      end
      on++;
    end
    chk("max release seen", rel_seen, 1);
    chk("max on cycles 6..7", int'(on >= 6 && on <= 7), 1);
    chk("max done0", done2, 3'b001);
    chk("max busy in release", busy2, 1);
    @(posedge clk);
    #1;
    chk("max done one cycle", done2, 0);
    got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      @(posedge clk);
      #1;
      got = int'(grant2 != 0);
    end
`ifdef TONE_ARB_ROUND_ROBIN_EN
    exp_regrant = 3'b010;
`else
    exp_regrant = 3'b001;
`endif
    chk("max regrant", grant2, exp_regrant);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
